accel_command_issuer: RTL
=========================

# accel_command_issuer

Command-side transmitter for the convolution accelerator. It accepts one layer descriptor through a valid/ready handshake and converts it into the accelerator's custom-instruction stream on the `instruction` bus. The stream is one reset pulse, one configuration word per register, then the trigger word. It then waits for `accel_done` and reports completion. It sits between the host/sequencing logic and the accelerator, and is the only driver of the accelerator's `instruction` and `rst_ext` inputs.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  descriptor fields below are valid.
- `cmd_ready`  out  1  issuer can accept a descriptor; high only in IDLE.
- `image_dim`  in  8  image width/height.
- `image_depth`  in  9  channel count.
- `image_offset`, `filter_offset`, `output_offset`  in  19 each  memory base addresses.
- `filter_halfsize`  in  2  filter half-width; also the image padding.
- `filter_stride`  in  3  convolution stride.
- `filter_length`  in  13  filter word count.
- `filter_bias`  in  18  bias value.
- `interrupt_addr`  in  19  interrupt vector value.
- `instruction`  out  32  instruction word to the accelerator.
- `accel_rst_ext`  out  1  accelerator reset request.
- `accel_done`  in  1  accelerator completion level.
- `layer_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Instruction format:
  - `[6:0]` is opcode `7'b0001011`.
  - `[11:7]` is `rd`.
  - `[31:12]` is `imm`, the field value zero-extended to 20 bits.
- Idle/NOP word: `32'h00000013`. It never carries the custom opcode.
- `rd` map, always emitted in ascending order:
  - 0 `image_dim`
  - 1 `image_depth`
  - 2 `image_offset`
  - 3 `filter_offset`
  - 4 `output_offset`
  - 5 `filter_halfsize`
  - 6 `filter_stride`
  - 7 `filter_length`
  - 8 `filter_bias`
  - 9 `interrupt_addr`
  - 31 trigger, with `imm` = 0
- Descriptor capture: on `cmd_valid & cmd_ready` all fields are latched into internal registers. Later input changes are ignored until the next acceptance.
- FSM states and transitions:
  - IDLE: `cmd_ready`=1, outputs NOP; on handshake → RESET.
  - RESET: `accel_rst_ext`=1 for exactly one cycle, `instruction`=NOP; → CONFIG with index 0.
  - CONFIG: emits one word per cycle for index 0..9. After index 9 → TRIGGER.
  - TRIGGER: emits `32'h00000F8B` for one cycle; → WAIT with guard counter = 2.
  - WAIT: outputs NOP. `accel_done` is ignored while the guard is nonzero (masks stale done). The first cycle with guard = 0 and `accel_done`=1 → DONE. There is no timeout.
  - DONE: `layer_done`=1 for one cycle; → IDLE.
- `accel_rst_ext` is never high in the same cycle as a custom-opcode word.
- Reset mid-operation: `rst` forces IDLE in the next cycle from any state. It also discards the descriptor and clears all skip history. No trigger is emitted after reset.

## Timing
- All outputs are registered.
- Reset values:
  - `instruction`=`32'h00000013`
  - `accel_rst_ext`=0
  - `layer_done`=0
  - `busy`=0
  - `cmd_ready`=1 (from the first cycle after reset deasserts)
- Handshake at edge E (full emission):
  - `accel_rst_ext` high during E+1.
  - Config words during E+2..E+11.
  - Trigger during E+12.
  - Earliest DONE at E+15, provided `accel_done` is already high.
- Back-to-back: `cmd_ready` returns high the cycle after DONE. The minimum spacing between accepted descriptors is therefore 16 cycles.

## Configuration
- Macro `ACCEL_ISSUER_SKIP_UNCHANGED_EN`.
- Defined: the issuer keeps a shadow copy and a valid bit per register (rd 0..9).
  - CONFIG visits only indices whose shadow is invalid or differs from the captured value. It advances through skipped indices in zero cycles, so there are no NOP gaps.
  - Shadows and valid bits update as each word issues.
  - `rst` clears all valid bits. The first descriptor after reset therefore always emits all ten words.
  - If nothing differs, TRIGGER follows RESET directly.
- Undefined: all ten words are emitted every time and no shadow state exists.

## Test plan
- Reset then idle 5 cycles:
  - `instruction`=`32'h00000013` throughout.
  - `cmd_ready`=1, `busy`=0, `accel_rst_ext`=0.
- Descriptor with `image_dim`=28 and `image_depth`=3:
  - `accel_rst_ext` pulses at E+1.
  - E+2 `instruction`=`32'h0001C00B`; E+3 `32'h0000308B`.
  - E+12 `32'h00000F8B`.
- `accel_done` held high from before the handshake:
  - DONE is not entered before E+15.
  - `layer_done` is a single pulse at E+15.
- Assert `rst` during CONFIG index 4:
  - Next cycle is IDLE with `instruction`=NOP.
  - No trigger word appears within the next 20 cycles.
- `cmd_valid` asserted while `busy`=1 with altered fields:
  - Not accepted.
  - Emitted words still match the first descriptor.
- With `ACCEL_ISSUER_SKIP_UNCHANGED_EN`, issue two descriptors differing only in `filter_bias` (5 → 6):
  - Second sequence is RESET, one `rd`=8 word `32'h0000640B`, then trigger at E+3.
  - Without the macro, ten words are emitted.

Source files
------------

// File: rtl/accel_command_issuer.sv
// accel_command_issuer: turns one accepted layer descriptor into the accelerator's custom-instruction stream.
// Optional macro ACCEL_ISSUER_SKIP_UNCHANGED_EN suppresses config words whose value matches the last one issued.
module accel_command_issuer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  image_dim,
    input  logic [8:0]  image_depth,
    input  logic [18:0] image_offset,
    input  logic [18:0] filter_offset,
    input  logic [18:0] output_offset,
    input  logic [1:0]  filter_halfsize,
    input  logic [2:0]  filter_stride,
    input  logic [12:0] filter_length,
    input  logic [17:0] filter_bias,
    input  logic [18:0] interrupt_addr,
    output logic [31:0] instruction,
    output logic        accel_rst_ext,
    input  logic        accel_done,
    output logic        layer_done,
    output logic        busy
);
    localparam int          NUM_REGS   = 10;
    localparam logic [6:0]  OPCODE     = 7'b0001011;
    localparam logic [4:0]  RD_TRIGGER = 5'd31;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [1:0]  GUARD_INIT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_CONFIG  = 3'd2,
        S_TRIGGER = 3'd3,
        S_WAIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [3:0]          idx_r, idx_s;
    logic [1:0]          guard_r, guard_s;
    logic [19:0]         desc_r  [NUM_REGS];
    logic [19:0]         field_s [NUM_REGS];
    logic [NUM_REGS-1:0] pending_s;
    logic [4:0]          next_s;
    logic                accept_s;
    logic [31:0]         instruction_r, instruction_s;
    logic                rst_ext_r, rst_ext_s;
    logic                layer_done_r, layer_done_s;
    logic                busy_r, cmd_ready_r;

    function automatic logic [31:0] make_word(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, OPCODE};
    endfunction

    // Lowest pending index at or above 'from'; bit 4 flags that one exists.
    function automatic logic [4:0] first_pending(input logic [NUM_REGS-1:0] mask,
                                                 input logic [3:0] from);
        logic [4:0] hit;
        hit = 5'd0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            hit = (mask[i] && (4'(i) >= from)) ? {1'b1, 4'(i)} : hit;
        end
        return hit;
    endfunction

    // Zero-extend every descriptor field to the 20-bit immediate, indexed by rd
    always_comb begin
        field_s[0] = {12'd0, image_dim};
        field_s[1] = {11'd0, image_depth};
        field_s[2] = {1'b0,  image_offset};
        field_s[3] = {1'b0,  filter_offset};
        field_s[4] = {1'b0,  output_offset};
        field_s[5] = {18'd0, filter_halfsize};
        field_s[6] = {17'd0, filter_stride};
        field_s[7] = {7'd0,  filter_length};
        field_s[8] = {2'd0,  filter_bias};
        field_s[9] = {1'b0,  interrupt_addr};
    end

`ifdef ACCEL_ISSUER_SKIP_UNCHANGED_EN
    logic [19:0]         shadow_r [NUM_REGS];
    logic [NUM_REGS-1:0] shadow_valid_r;

    // A register needs a word when the accelerator has no copy yet or a stale one
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_s[i] = !shadow_valid_r[i] || (shadow_r[i] != desc_r[i]);
        end
    end

    // Shadow follows each config word as it is loaded into the instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_valid_r <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= 20'd0;
            end
        end else if (state_s == S_CONFIG) begin
            shadow_r[idx_s]       <= desc_r[idx_s];
            shadow_valid_r[idx_s] <= 1'b1;
        end
    end
`else
    assign pending_s = {NUM_REGS{1'b1}};
`endif

    assign accept_s = cmd_valid && cmd_ready_r;

    // Next-state logic and decode of the outputs that belong to the next state
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        guard_s       = guard_r;
        next_s        = 5'd0;
        instruction_s = NOP_WORD;
        rst_ext_s     = 1'b0;
        layer_done_s  = 1'b0;

        case (state_r)
            S_IDLE: begin
                state_s = accept_s ? S_RESET : S_IDLE;
            end
            S_RESET: begin
                next_s = first_pending(pending_s, 4'd0);
                if (next_s[4]) begin
                    state_s = S_CONFIG;
                    idx_s   = next_s[3:0];
                end else begin
                    state_s = S_TRIGGER;
                end
            end
            S_CONFIG: begin
                next_s = first_pending(pending_s, idx_r + 4'd1);
                if (next_s[4]) begin
                    state_s = S_CONFIG;
                    idx_s   = next_s[3:0];
                end else begin
                    state_s = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                state_s = S_WAIT;
                guard_s = GUARD_INIT;
            end
            S_WAIT: begin
                // done is honoured once the guard has drained to zero on this edge
                guard_s = (guard_r != 2'd0) ? (guard_r - 2'd1) : 2'd0;
                if ((guard_s == 2'd0) && accel_done) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        case (state_s)
            S_RESET:   rst_ext_s     = 1'b1;
            S_CONFIG:  instruction_s = make_word({1'b0, idx_s}, desc_r[idx_s]);
            S_TRIGGER: instruction_s = make_word(RD_TRIGGER, 20'd0);
            S_DONE:    layer_done_s  = 1'b1;
            default:   instruction_s = NOP_WORD;
        endcase
    end

    // State, captured descriptor and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            idx_r         <= 4'd0;
            guard_r       <= 2'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                desc_r[i] <= 20'd0;
            end
            instruction_r <= NOP_WORD;
            rst_ext_r     <= 1'b0;
            layer_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            cmd_ready_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            guard_r <= guard_s;
            if (accept_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    desc_r[i] <= field_s[i];
                end
            end
            instruction_r <= instruction_s;
            rst_ext_r     <= rst_ext_s;
            layer_done_r  <= layer_done_s;
            busy_r        <= (state_s != S_IDLE);
            cmd_ready_r   <= (state_s == S_IDLE);
        end
    end

    assign instruction   = instruction_r;
    assign accel_rst_ext = rst_ext_r;
    assign layer_done    = layer_done_r;
    assign busy          = busy_r;
    assign cmd_ready     = cmd_ready_r;

endmodule
